imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: instruction word width.
REQ-002 Parameter DEPTH, default 256: memory depth in words, power of two, at least 4.
REQ-003 Parameter BOOT_ADDR, default 32'h00000000: byte address of word 0.
REQ-004 Parameter NOP_INST, default 32'h00000013: bubble instruction.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 imem_addr  in  32  fetch byte address from the core PC.
REQ-008 if_stall  in  1  holds if_id_instruction and fetch_fault.
REQ-009 if_flush  in  1  replaces the next fetched word with NOP_INST.
REQ-010 load_valid  in  1  loader word valid.
REQ-011 load_ready  out  1  loader word accepted when load_valid and load_ready are both high.
REQ-012 load_data  in  DATA_WIDTH  loader word.
REQ-013 load_last  in  1  marks the final loader word.
REQ-014 reload  in  1  single-cycle request to re-enter LOAD from RUN.
REQ-015 core_hold  out  1  high while the core must stay in reset/hold (state not RUN).
REQ-016 if_id_instruction  out  DATA_WIDTH  registered fetched word.
REQ-017 fetch_fault  out  1  registered flag: last fetch was misaligned or out of range.
REQ-018 load_count  out  $clog2(DEPTH)+1  number of words written in the current load.

Function
REQ-019 The block SHALL have two states: LOAD and RUN.
REQ-020 In LOAD, load_ready SHALL be 1 and core_hold SHALL be 1; in RUN, load_ready SHALL be 0 and core_hold SHALL be 0 (both registered from state).
REQ-021 Each accepted load word SHALL be written to mem[load_count], after which load_count SHALL increment by 1.
REQ-022 LOAD SHALL go to RUN on the cycle after an accepted word with load_last=1, or after the DEPTH-th accepted word regardless of load_last.
REQ-023 load_count SHALL saturate at DEPTH; no write SHALL occur beyond index DEPTH-1.
REQ-024 In RUN, reload=1 SHALL move the block to LOAD and clear load_count to 0; memory contents SHALL be kept.
REQ-025 reload SHALL be ignored in LOAD.
REQ-026 Fetch index SHALL be (imem_addr - BOOT_ADDR) >> 2, computed modulo 2^32.
REQ-027 A fetch SHALL be valid when imem_addr[1:0]==0 and (imem_addr - BOOT_ADDR) < DEPTH*4.
REQ-028 Read latency SHALL be 1 cycle: imem_addr at edge N gives if_id_instruction after edge N+1 (registered, synchronous-read RAM).
REQ-029 Per-edge update priority SHALL be: state==LOAD -> NOP_INST, fault 0; else if_flush -> NOP_INST, fault 0; else if_stall -> hold both; else valid fetch -> mem word, fault 0; else -> NOP_INST, fault 1.
REQ-030 if_flush and if_stall asserted together SHALL behave as flush.
REQ-031 Words beyond load_count (never loaded) SHALL read whatever the RAM holds; no tracking is required.
REQ-032 A load write and a fetch read in the same cycle cannot occur, because fetches are suppressed in LOAD.

Reset
REQ-033 reset SHALL asynchronously set: state LOAD, load_count 0, if_id_instruction NOP_INST, fault 0, load_ready 1, core_hold 1.
REQ-034 RAM contents SHALL NOT be reset.
REQ-035 A reset asserted mid-load SHALL abandon that load; the next load restarts at index 0.
REQ-036 Deassertion SHALL be used only through the caller-provided synchronizer; the block adds none.

Structure
REQ-037 NOP_INST and the state encoding (LOAD=1'b0, RUN=1'b1) SHALL live in the shared core package and be reused by the control unit.
REQ-038 The RAM SHALL be a single sub-module, imem_ram (1 write port, 1 registered read port, no reset), so it can be replaced by a vendor macro.
REQ-039 All other logic (FSM, counter, address check, output register) SHALL be in imem_responder.

Verification
REQ-040 Reset, then load 3 words 0xA, 0xB, 0xC with last on 0xC -> load_count=3, core_hold falls 1 cycle after the 0xC handshake; imem_addr 0x4 -> if_id_instruction=0xB next cycle.
REQ-041 Load DEPTH words with load_last never asserted -> RUN after word DEPTH, load_count=DEPTH, no further load_ready.
REQ-042 In RUN, imem_addr=0x2 -> NOP_INST with fault=1; imem_addr=DEPTH*4 -> NOP_INST with fault=1; imem_addr=0x0 -> fault=0.
REQ-043 Stall for 3 cycles while the address changes -> output held; flush and stall together -> NOP_INST next cycle.
REQ-044 Reset asserted after 2 of 5 load words -> load_count=0 immediately (asynchronously), LOAD, output NOP_INST; a new load writes from index 0.
REQ-045 reload pulse in RUN -> core_hold=1 next cycle, load_count=0; fetch of a previously loaded address after re-entering RUN returns the old word if it was not overwritten.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction memory responder and the core control unit.
package imem_responder_pkg;

  localparam logic [31:0] NopInst = 32'h0000_0013;

  typedef enum logic {
    StLoad = 1'b0,
    StRun  = 1'b1
  } imem_state_e;

  typedef enum logic {
    SelNop = 1'b0,
    SelMem = 1'b1
  } imem_out_sel_e;

endpackage

// File: rtl/imem_ram.sv
// Single-port-write, registered-read instruction RAM with no reset; swappable for a vendor macro.
module imem_ram #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 256,
  parameter int unsigned AddrW     = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrW-1:0]     waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [AddrW-1:0]     raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    // Read register holds its value when re_i is low, which implements fetch stall.
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory responder: loader-fed RAM with LOAD/RUN control and a registered fetch port.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 256,
  parameter logic [31:0]           BOOT_ADDR  = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(NopInst)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             imem_addr,
  input  logic                    if_stall,
  input  logic                    if_flush,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [DATA_WIDTH-1:0]   load_data,
  input  logic                    load_last,
  input  logic                    reload,
  output logic                    core_hold,
  output logic [DATA_WIDTH-1:0]   if_id_instruction,
  output logic                    fetch_fault,
  output logic [$clog2(DEPTH):0]  load_count
);

  localparam int unsigned    AddrW    = $clog2(DEPTH);
  localparam int unsigned    CntW     = AddrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [31:0]    ByteSpan = 32'(DEPTH * 4);

  imem_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  imem_out_sel_e   sel_q, sel_d;
  logic            fault_q, fault_d;

  logic                  load_accept;
  logic                  ram_we;
  logic                  ram_re;
  logic [31:0]           offset;
  logic                  fetch_ok;
  logic [AddrW-1:0]      ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Load FSM and word counter
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_accept = load_valid && (state_q == StLoad);
    ram_we      = load_accept && (cnt_q < DepthCnt);
    unique case (state_q)
      StLoad: begin
        if (load_accept) begin
          if (cnt_q < DepthCnt) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (load_last || (cnt_q == DepthCnt - 1'b1)) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (reload) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Fetch address check; subtraction wraps so addresses below BOOT_ADDR fall out of range.
  always_comb begin
    offset    = imem_addr - BOOT_ADDR;
    fetch_ok  = (imem_addr[1:0] == 2'b00) && (offset < ByteSpan);
    ram_raddr = offset[AddrW+1:2];
  end

  always_comb begin
    sel_d   = sel_q;
    fault_d = fault_q;
    ram_re  = 1'b0;
    if (state_q == StLoad) begin
      sel_d   = SelNop;
      fault_d = 1'b0;
    end else if (if_flush) begin
      sel_d   = SelNop;
      fault_d = 1'b0;
    end else if (if_stall) begin
      sel_d   = sel_q;
      fault_d = fault_q;
    end else if (fetch_ok) begin
      sel_d   = SelMem;
      fault_d = 1'b0;
      ram_re  = 1'b1;
    end else begin
      sel_d   = SelNop;
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      sel_q   <= SelNop;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      fault_q <= fault_d;
    end
  end

  imem_ram #(
    .DataWidth (DATA_WIDTH),
    .Depth     (DEPTH),
    .AddrW     (AddrW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (cnt_q[AddrW-1:0]),
    .wdata_i (load_data),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    load_ready        = (state_q == StLoad);
    core_hold         = (state_q == StLoad);
    load_count        = cnt_q;
    fetch_fault       = fault_q;
    if_id_instruction = (sel_q == SelMem) ? ram_rdata : NOP_INST;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: table vectors, directed corner sequences, random vs model.
module tb_imem_responder;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] BOOT  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   imem_addr;
  logic          if_stall;
  logic          if_flush;
  logic          load_valid;
  logic          load_ready;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          reload;
  logic          core_hold;
  logic [DW-1:0] if_id_instruction;
  logic          fetch_fault;
  logic [CW-1:0] load_count;

  always #5 clk = ~clk;

  imem_responder #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .BOOT_ADDR  (BOOT),
    .NOP_INST   (NOP)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .imem_addr         (imem_addr),
    .if_stall          (if_stall),
    .if_flush          (if_flush),
    .load_valid        (load_valid),
    .load_ready        (load_ready),
    .load_data         (load_data),
    .load_last         (load_last),
    .reload            (reload),
    .core_hold         (core_hold),
    .if_id_instruction (if_id_instruction),
    .fetch_fault       (fetch_fault),
    .load_count        (load_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: memory image plus "which words were ever written".
  logic [31:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  bit          m_run;
  int          m_cnt;
  logic [31:0] m_inst;
  bit          m_fault;
  bit          m_known;

  typedef struct {
    logic [31:0] addr;
    bit          stall;
    bit          flush;
    logic [31:0] inst;
    bit          fault;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run   = 0;
    m_cnt   = 0;
    m_inst  = NOP;
    m_fault = 0;
    m_known = 1;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    logic [31:0] off;
    off = imem_addr - BOOT;
    if (!m_run || if_flush) begin
      m_inst = NOP; m_fault = 0; m_known = 1;
    end else if (if_stall) begin
      // hold
    end else if (imem_addr % 4 == 0 && off < DEPTH * 4) begin
      m_inst  = m_mem[off / 4];
      m_known = m_wr[off / 4];
      m_fault = 0;
    end else begin
      m_inst = NOP; m_fault = 1; m_known = 1;
    end
    if (!m_run && load_valid) begin
      m_mem[m_cnt] = load_data;
      m_wr[m_cnt]  = 1;
      m_cnt++;
      if (load_last || m_cnt == DEPTH) m_run = 1;
    end else if (m_run && reload) begin
      m_run = 0;
      m_cnt = 0;
    end
  endtask

  task automatic compare_all();
    if (m_known) check("inst", if_id_instruction, m_inst);
    check("fault", 32'(fetch_fault), 32'(m_fault));
    check("load_count", 32'(load_count), 32'(m_cnt));
    check("core_hold", 32'(core_hold), 32'(!m_run));
    check("load_ready", 32'(load_ready), 32'(!m_run));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    imem_addr = 0; if_stall = 0; if_flush = 0;
    load_valid = 0; load_data = 0; load_last = 0; reload = 0;
  endtask

  task automatic load_word(input logic [31:0] d, input bit last);
    load_valid = 1; load_data = d; load_last = last;
    step();
    load_valid = 0; load_last = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    imem_addr = a;
    step();
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) m_wr[i] = 0;
    clear_inputs();
    do_reset();
    check("reset_inst", if_id_instruction, NOP);
    check("reset_count", 32'(load_count), 32'd0);

    // Basic load of three words, last on the third
    load_word(32'hA, 0);
    load_word(32'hB, 0);
    check("hold_before_last", 32'(core_hold), 32'd1);
    load_word(32'hC, 1);
    check("count_after_abc", 32'(load_count), 32'd3);
    check("hold_after_last", 32'(core_hold), 32'd0);
    fetch(32'h4);
    check("fetch4_is_b", if_id_instruction, 32'hB);

    vecs[0]  = '{32'h0,        0, 0, 32'hA, 0};
    vecs[1]  = '{32'h4,        0, 0, 32'hB, 0};
    vecs[2]  = '{32'h8,        0, 0, 32'hC, 0};
    vecs[3]  = '{32'h2,        0, 0, NOP,   1};
    vecs[4]  = '{DEPTH * 4,    0, 0, NOP,   1};
    vecs[5]  = '{32'h4,        0, 1, NOP,   0};
    vecs[6]  = '{32'h8,        1, 0, NOP,   0};
    vecs[7]  = '{32'h0,        0, 0, 32'hA, 0};
    vecs[8]  = '{32'hC,        1, 0, 32'hA, 0};
    vecs[9]  = '{32'h8,        1, 1, NOP,   0};
    vecs[10] = '{32'hFFFF_FFFC, 0, 0, NOP,  1};
    vecs[11] = '{32'h8,        0, 0, 32'hC, 0};
    for (int i = 0; i < 12; i++) begin
      imem_addr = vecs[i].addr; if_stall = vecs[i].stall; if_flush = vecs[i].flush;
      step();
      check($sformatf("vec%0d_inst", i), if_id_instruction, vecs[i].inst);
      check($sformatf("vec%0d_fault", i), 32'(fetch_fault), 32'(vecs[i].fault));
    end
    clear_inputs();

    // Stall three cycles while the address moves, then flush+stall
    fetch(32'h4);
    if_stall = 1;
    foreach (vecs[i]) if (i < 3) begin
      imem_addr = (i == 2) ? 32'h2 : 32'(i) * 8;
      step();
      check($sformatf("stall%0d_inst", i), if_id_instruction, 32'hB);
      check($sformatf("stall%0d_fault", i), 32'(fetch_fault), 32'd0);
    end
    if_flush = 1;
    step();
    check("flush_stall_inst", if_id_instruction, NOP);
    clear_inputs();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      imem_addr  = ($urandom_range(0, 99) < 75) ? $urandom_range(0, DEPTH - 1) * 4 : $urandom;
      if_stall   = ($urandom_range(0, 3) == 0);
      if_flush   = ($urandom_range(0, 7) == 0);
      reload     = ($urandom_range(0, 39) == 0);
      load_valid = ($urandom_range(0, 1) == 1);
      load_data  = $urandom;
      load_last  = ($urandom_range(0, 5) == 0);
      step();
    end
    clear_inputs();

    // Full-depth load with no last marker
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) load_word(32'h100 + 32'(i), 0);
    check("full_count", 32'(load_count), DEPTH);
    check("full_hold", 32'(core_hold), 32'd0);
    load_valid = 1; load_data = 32'hDEAD;
    step();
    step();
    check("full_no_ready", 32'(load_ready), 32'd0);
    check("full_count_sat", 32'(load_count), DEPTH);
    clear_inputs();
    for (int i = 0; i < int'(DEPTH); i++) fetch(32'(i) * 4);
    check("full_last_word", if_id_instruction, 32'h100 + DEPTH - 1);

    // Reset in the middle of a load
    reload = 1;
    step();
    reload = 0;
    check("reload_hold", 32'(core_hold), 32'd1);
    check("reload_count", 32'(load_count), 32'd0);
    load_word(32'h200, 0);
    load_word(32'h201, 0);
    check("mid_count2", 32'(load_count), 32'd2);
    #2;
    reset = 1;
    model_reset();
    #1;
    check("async_count", 32'(load_count), 32'd0);
    check("async_hold", 32'(core_hold), 32'd1);
    check("async_inst", if_id_instruction, NOP);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 5; i++) load_word(32'h300 + 32'(i), i == 4);
    check("reload5_count", 32'(load_count), 32'd5);
    fetch(32'h0);
    check("restart_idx0", if_id_instruction, 32'h300);
    fetch(32'h10);
    check("restart_idx4", if_id_instruction, 32'h304);
    fetch(32'h14);
    check("old_idx5", if_id_instruction, 32'h105);

    // Reload keeps memory; only index 0 is overwritten
    reload = 1;
    step();
    reload = 0;
    check("reload2_hold", 32'(core_hold), 32'd1);
    check("reload2_count", 32'(load_count), 32'd0);
    load_word(32'h400, 1);
    fetch(32'h8);
    check("kept_idx2", if_id_instruction, 32'h302);
    fetch(32'h0);
    check("new_idx0", if_id_instruction, 32'h400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
